// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit buffer: sequencer states,
// byte width and the clocks-per-bit calculation.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

    function automatic int bit_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with a combinational head output and an occupancy
// count whose extra bit separates full from empty.
module uart_sync_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   level_q;
    logic              push_ok;
    logic              pop_ok;

    // full/empty come from the registered level, so a push is refused when
    // the FIFO was full at the start of the cycle even if a pop happens too.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (level_q == (ADDR_W + 1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr_q];

    // NOTE: the storage array has no reset; stale entries are never visible
    // because the pointers and level are reset, and leaving it out keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + (ADDR_W + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                level_q <= level_q - (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue plus send sequencer feeding the UART transmitter through the
// tx_en / tx_data / tx_finish handshake, with a stuck-transmitter watchdog.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int CLK_Period   = 50000000,
    parameter int Buad_Rate    = 9600,
    parameter int ADDR_W       = 4,
    parameter int GAP_CYC      = 0,
    parameter int TIMEOUT_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   overflow,
    output logic                   tx_timeout,
    input  logic                   clr_err,
    output logic                   busy,
    output logic                   tx_en,
    output logic [UART_BYTE_W-1:0] tx_data,
    input  logic                   tx_finish
);

    localparam int WD_LIMIT = TIMEOUT_BITS * bit_period(CLK_Period, Buad_Rate);
    localparam int WD_W     = (WD_LIMIT > 2) ? $clog2(WD_LIMIT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    tx_state_e              state_q;
    logic [WD_W-1:0]        wd_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   tx_en_q;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic                   overflow_q;
    logic                   timeout_q;
    logic [UART_BYTE_W-1:0] head;
    logic                   pop;
    logic                   timeout_hit;

    assign pop         = (state_q == IDLE) && !empty;
    // A tx_finish arriving on the limit cycle wins over the watchdog.
    assign timeout_hit = (state_q == WAIT) && !tx_finish && (wd_q == WD_LAST);

    uart_sync_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (UART_BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // NOTE: all state here updates with non-blocking assignments so every
    // branch sees the values from the start of the cycle, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wd_q      <= '0;
            gap_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        tx_data_q <= head;
                        tx_en_q   <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    // Restart the watchdog; it counts the tx_en cycle itself.
                    wd_q    <= WD_W'(1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (tx_finish) begin
                        gap_q   <= '0;
                        state_q <= (GAP_CYC == 0) ? IDLE : GAP;
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end else if (clr_err) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign overflow   = overflow_q;
    assign tx_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: latency, burst ordering, overflow,
// watchdog timeout, inter-byte gap and asynchronous reset flush.
module tb_uart_tx_buffer;

    logic       clk;
    logic       rst_n;
    logic       wr_en, clr_err, tx_finish;
    logic [7:0] wr_data;
    logic       full, empty, overflow, tx_timeout, busy, tx_en;
    logic [4:0] level;
    logic [7:0] tx_data;

    logic       g_wr_en, g_clr_err, g_tx_finish;
    logic [7:0] g_wr_data;
    logic       g_full, g_empty, g_overflow, g_tx_timeout, g_busy, g_tx_en;
    logic [4:0] g_level;
    logic [7:0] g_tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .tx_timeout (tx_timeout),
        .clr_err    (clr_err),
        .busy       (busy),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_finish  (tx_finish)
    );

    uart_tx_buffer #(.GAP_CYC(3)) dut_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (g_wr_en),
        .wr_data    (g_wr_data),
        .full       (g_full),
        .empty      (g_empty),
        .level      (g_level),
        .overflow   (g_overflow),
        .tx_timeout (g_tx_timeout),
        .clr_err    (g_clr_err),
        .busy       (g_busy),
        .tx_en      (g_tx_en),
        .tx_data    (g_tx_data),
        .tx_finish  (g_tx_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits until the selected DUT raises tx_en; waited = clock edges consumed.
    task automatic wait_tx(input bit sel, input int budget, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if ((sel ? g_tx_en : tx_en) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            waited++;
        end
    endtask

    task automatic pulse_finish(input bit sel);
        if (sel) g_tx_finish = 1'b1; else tx_finish = 1'b1;
        tick();
        g_tx_finish = 1'b0;
        tx_finish   = 1'b0;
    endtask

    initial begin
        int  waited;
        bit  ok;
        int  cnt;

        rst_n = 1'b0;
        wr_en = 1'b0; wr_data = '0; clr_err = 1'b0; tx_finish = 1'b0;
        g_wr_en = 1'b0; g_wr_data = '0; g_clr_err = 1'b0; g_tx_finish = 1'b0;

        #2;
        check("rst tx_en", tx_en, 0);
        check("rst busy", busy, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst level", level, 0);
        check("rst overflow", overflow, 0);
        check("rst tx_timeout", tx_timeout, 0);
        check("rst tx_data", tx_data, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single byte: push in cycle 0, tx_en in cycle 2.
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("t1 tx_en c1", tx_en, 0);
        tick();
        check("t1 tx_en c2", tx_en, 1);
        check("t1 tx_data", tx_data, 8'hA5);
        check("t1 empty c2", empty, 1);
        check("t1 busy c2", busy, 1);
        tick();
        check("t1 tx_en c3", tx_en, 0);
        repeat (3) tick();
        check("t1 busy wait", busy, 1);
        pulse_finish(0);
        check("t1 busy after finish", busy, 0);

        // Hold the transmitter on a primer byte so the burst fills the FIFO.
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        wait_tx(0, 10, waited, ok);
        check("t2 primer seen", ok, 1);
        check("t2 primer data", tx_data, 8'h5A);
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t2 full", full, 1);
        check("t2 level 16", level, 16);
        check("t2 tx_data stable", tx_data, 8'h5A);

        // Overflow push with a simultaneous clr_err: the set must win.
        wr_en = 1'b1; wr_data = 8'hEE; clr_err = 1'b1;
        tick();
        wr_en = 1'b0; clr_err = 1'b0;
        check("t3 overflow set", overflow, 1);
        check("t3 level still 16", level, 16);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3 overflow cleared", overflow, 0);

        pulse_finish(0);
        for (int i = 0; i < 16; i++) begin
            wait_tx(0, 10, waited, ok);
            check("t2 tx_en seen", ok, 1);
            check("t2 finish-to-tx_en", waited + 1, 2);
            check("t2 order", tx_data, i);
            check("t2 level", level, 15 - i);
            tick();
            check("t2 single pulse", tx_en, 0);
            repeat (2) tick();
            pulse_finish(0);
        end
        check("t2 drained empty", empty, 1);
        check("t2 drained level", level, 0);
        cnt = 0;
        repeat (10) begin
            if (tx_en === 1'b1) cnt++;
            tick();
        end
        check("t3 0xEE not sent", cnt, 0);
        check("t2 idle", busy, 0);

        // Watchdog: no tx_finish for 0x11; 0x22 starts right after the timeout.
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_en = 1'b0;
        check("t4 tx_en", tx_en, 1);
        check("t4 tx_data", tx_data, 8'h11);
        cnt = 0;
        while (tx_timeout !== 1'b1 && cnt < 70000) begin
            tick();
            cnt++;
        end
        check("t4 timeout latency", cnt, 62496);
        check("t4 timeout flag", tx_timeout, 1);
        check("t4 idle at timeout", busy, 0);
        tick();
        check("t4 next tx_en", tx_en, 1);
        check("t4 next tx_data", tx_data, 8'h22);
        check("t4 timeout sticky", tx_timeout, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4 timeout cleared", tx_timeout, 0);
        pulse_finish(0);
        check("t4 done", busy, 0);

        // GAP_CYC = 3: tx_finish in cycle N, next tx_en in cycle N+5.
        g_wr_en = 1'b1; g_wr_data = 8'h31;
        tick();
        g_wr_data = 8'h32;
        tick();
        g_wr_en = 1'b0;
        wait_tx(1, 10, waited, ok);
        check("t5 first seen", ok, 1);
        check("t5 first data", g_tx_data, 8'h31);
        repeat (2) tick();
        pulse_finish(1);
        check("t5 busy in gap", g_busy, 1);
        wait_tx(1, 20, waited, ok);
        check("t5 second seen", ok, 1);
        check("t5 finish-to-tx_en", waited + 1, 5);
        check("t5 second data", g_tx_data, 8'h32);
        repeat (3) tick();
        pulse_finish(1);
        repeat (4) tick();
        check("t5 idle", g_busy, 0);
        check("t5 empty", g_empty, 1);

        // Reset mid-WAIT with five bytes still queued.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        check("t6 level before rst", level, 5);
        check("t6 busy before rst", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 empty", empty, 1);
        check("t6 level", level, 0);
        check("t6 tx_en", tx_en, 0);
        check("t6 busy", busy, 0);
        check("t6 tx_data", tx_data, 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            tick();
            if (tx_en === 1'b1) cnt++;
        end
        check("t6 no tx after flush", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
